// File: rtl/key_event_queue.sv
// Keyboard event queue: detects make/break events from the keyboard driver and
// buffers them in a first-word-fall-through FIFO with a sticky overflow flag.
module key_event_queue #(
    parameter int DEPTH_LOG2 = 4,
    parameter bit ENQ_BREAK  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            key_status,
    input  logic [7:0]            keycode,
    input  logic                  pop,
    input  logic                  clear_overflow,
    output logic                  event_valid,
    output logic [11:0]           event_data,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow
);

    localparam logic [DEPTH_LOG2:0]   FULL    = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = (DEPTH_LOG2)'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE = (DEPTH_LOG2+1)'(1);

    logic [11:0]           mem [(1 << DEPTH_LOG2)];
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [7:0]            last_code;
    logic                  last_break;

    logic make_evt;
    logic break_evt;
    logic push;
    logic pop_acc;
    logic push_acc;
    logic drop;

    always_comb begin
        make_evt  = !key_status[0] && (keycode != '0) &&
                    ((keycode != last_code) || last_break);
        break_evt = ENQ_BREAK && key_status[1];
        push      = make_evt || break_evt;
        pop_acc   = pop && (count != '0);
        // A full queue still accepts a push when the same cycle frees a slot.
        push_acc  = push && ((count != FULL) || pop_acc);
        drop      = push && !push_acc;
    end

    assign event_valid = (count != '0);
    assign event_data  = (count == '0) ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_acc && !rst) begin
            mem[wr_ptr] <= {key_status[0], key_status[4:2], keycode};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            last_code  <= '0;
            last_break <= 1'b0;
        end else begin
            last_code  <= keycode;
            last_break <= key_status[0];
            if (push_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_acc) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push_acc, pop_acc})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end else if (clear_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_key_event_queue.sv
// Directed bench for key_event_queue: hand-computed expectations for make/break
// detection, typematic suppression, fill/overflow, empty edge cases and reset.
module tb_key_event_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  key_status;
    logic [7:0]  keycode;
    logic        pop;
    logic        clear_overflow;
    logic        event_valid;
    logic [11:0] event_data;
    logic [4:0]  count;
    logic        overflow;
    logic        nb_valid;
    logic [11:0] nb_data;
    logic [4:0]  nb_count;
    logic        nb_overflow;

    int unsigned vectors = 0;
    int unsigned errors  = 0;

    always #5 clk = ~clk;

    key_event_queue #(.DEPTH_LOG2(4), .ENQ_BREAK(1'b1)) dut (
        .clk(clk), .rst(rst), .key_status(key_status), .keycode(keycode),
        .pop(pop), .clear_overflow(clear_overflow), .event_valid(event_valid),
        .event_data(event_data), .count(count), .overflow(overflow)
    );

    // Same stimulus, break events disabled.
    key_event_queue #(.DEPTH_LOG2(4), .ENQ_BREAK(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .key_status(key_status), .keycode(keycode),
        .pop(pop), .clear_overflow(clear_overflow), .event_valid(nb_valid),
        .event_data(nb_data), .count(nb_count), .overflow(nb_overflow)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_state(input string tag, input logic valid, input int unsigned cnt,
                                input logic [11:0] data);
        check({tag, ".valid"}, 16'(event_valid), 16'(valid));
        check({tag, ".count"}, 16'(count), 16'(cnt));
        check({tag, ".data"},  16'(event_data), 16'(data));
    endtask

    task automatic tick(input int unsigned n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1; key_status = '0; keycode = '0; pop = 1'b0; clear_overflow = 1'b0;
        tick(2);
        expect_state("reset", 1'b0, 0, 12'h000);
        check("reset.ovf", 16'(overflow), 16'h0);
        rst = 1'b0;
        tick();
        expect_state("idle", 1'b0, 0, 12'h000);

        // Make then break of 0x1C
        keycode = 8'h1C;
        tick();
        expect_state("make1c", 1'b1, 1, 12'h01C);
        tick(19);
        check("held1c.count", 16'(count), 16'd1);
        key_status = 8'h03;
        tick();
        check("break1c.count", 16'(count), 16'd2);
        key_status = 8'h00; keycode = 8'h00;
        tick();
        expect_state("after_break", 1'b1, 2, 12'h01C);
        check("nobreak.count", 16'(nb_count), 16'd1);
        check("nobreak.data", 16'(nb_data), 16'h01C);
        pop = 1'b1;
        tick();
        expect_state("pop1", 1'b1, 1, 12'h81C);
        tick();
        pop = 1'b0;
        expect_state("pop2", 1'b0, 0, 12'h000);

        // Typematic repeats suppressed
        keycode = 8'h23;
        tick(100);
        check("typematic.count", 16'(count), 16'd1);
        keycode = 8'h24;
        tick();
        keycode = 8'h00;
        tick();
        expect_state("typ2", 1'b1, 2, 12'h023);
        pop = 1'b1;
        tick();
        check("typ.second", 16'(event_data), 16'h024);
        tick();
        pop = 1'b0;
        check("typ.empty", 16'(count), 16'd0);

        // Modifiers captured, key_status[7:5] ignored
        key_status = 8'hF4; keycode = 8'h55;
        tick();
        key_status = 8'h00; keycode = 8'h00;
        tick();
        expect_state("mods", 1'b1, 1, 12'h555);
        pop = 1'b1;
        tick();
        pop = 1'b0;

        // Fill to 16, drop the 17th
        for (int i = 1; i <= 17; i++) begin
            keycode = 8'(i);
            tick();
        end
        expect_state("full", 1'b1, 16, 12'h001);
        check("full.ovf", 16'(overflow), 16'h1);
        keycode = 8'h12; clear_overflow = 1'b1;
        tick();
        check("drop_vs_clear.ovf", 16'(overflow), 16'h1);
        check("drop_vs_clear.count", 16'(count), 16'd16);
        keycode = 8'h00;
        tick();
        clear_overflow = 1'b0;
        check("cleared.ovf", 16'(overflow), 16'h0);
        keycode = 8'h77; pop = 1'b1;
        tick();
        keycode = 8'h00; pop = 1'b0;
        expect_state("full_pushpop", 1'b1, 16, 12'h002);
        check("full_pushpop.ovf", 16'(overflow), 16'h0);
        pop = 1'b1;
        for (int i = 2; i <= 16; i++) begin
            check("drain", 16'(event_data), 16'(i));
            tick();
        end
        check("drain.tail", 16'(event_data), 16'h077);
        tick();
        pop = 1'b0;
        expect_state("drained", 1'b0, 0, 12'h000);

        // Empty edge cases
        pop = 1'b1;
        tick();
        expect_state("pop_empty", 1'b0, 0, 12'h000);
        keycode = 8'h3A;
        tick();
        keycode = 8'h00; pop = 1'b0;
        expect_state("push_pop_empty", 1'b1, 1, 12'h03A);
        pop = 1'b1;
        tick();
        pop = 1'b0;
        check("empty_again", 16'(count), 16'd0);

        // Reset mid-run with a push pending, then held code queued out of reset
        for (int i = 0; i < 5; i++) begin
            keycode = 8'(8'h41 + i);
            tick();
        end
        check("five.count", 16'(count), 16'd5);
        keycode = 8'h46; rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_state("midreset", 1'b0, 0, 12'h000);
        check("midreset.ovf", 16'(overflow), 16'h0);
        tick();
        expect_state("post_reset_make", 1'b1, 1, 12'h046);
        keycode = 8'h00;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
